spi_controller: RTL
===================

Name: spi_controller

Overview:
SPI controller that originates the two-byte register-access frames consumed by spi_peripheral. A frame is a command byte {wr_rdn, addr} followed by a data byte, both MSB first. During the command byte the controller captures the status byte returned on MISO. During the data byte it either shifts out wdata (write) or captures rdata (read). It sits between a local host (start/done handshake) and the chip-level SPI pins, and generates spi_clk by dividing the system clock.

Parameters:
REG_W, 8, register/byte width; address is REG_W-1 bits.
CLK_DIV, 4, spi_clk half-period in clk cycles. Legal range is 4..255; the peripheral's edge detection needs at least 4.
GAP_CYC, 8, idle clk cycles between command byte and data byte, with spi_clk at its idle level. Legal range is 1..255.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ena  input  1  clock enable; when low, all state and outputs hold
mode  input  2  {CPOL, CPHA}; sampled when start is accepted
start  input  1  request a frame; accepted only in IDLE with ena high
wr_rdn  input  1  1 = write, 0 = read; latched on accept
addr  input  REG_W-1  register address; latched on accept
wdata  input  REG_W  write data; latched on accept
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion
rdata  output  REG_W  read data; updated at done for read frames only
status  output  REG_W  status byte captured during command byte
spi_clk  output  1  serial clock, registered
spi_mosi  output  1  serial data out, registered
spi_miso  input  1  serial data in
spi_cs_n  output  1  chip select, active-low, registered

Behaviour:
- Reset values: busy=0, done=0, rdata=0, status=0, spi_cs_n=1, spi_clk=0, spi_mosi=0, FSM=IDLE.
- In IDLE, spi_clk is updated to mode[1] on every enabled cycle. It does not toggle.
- Accept: start=1 in IDLE with ena=1.
  - Latch mode, wr_rdn, addr, wdata.
  - Next edge: spi_cs_n=0, busy=1.
  - start while busy is ignored; no queuing.
- FSM: IDLE -> SETUP -> BYTE1 -> GAP -> BYTE2 -> HOLD -> RECOVER -> IDLE.
- Timing, with t0 = the clk edge where spi_cs_n falls and k = 0..REG_W-1:
  - BYTE1 leading edge k at t0+CLK_DIV*(2k+1); trailing edge k at t0+CLK_DIV*(2k+2).
  - GAP lasts GAP_CYC cycles after the last BYTE1 trailing edge.
  - BYTE2 uses the same edge formula, offset by 2*REG_W*CLK_DIV+GAP_CYC.
  - spi_cs_n rises CLK_DIV cycles after the last BYTE2 trailing edge (HOLD).
  - CS-low width = (4*REG_W+1)*CLK_DIV+GAP_CYC cycles; 140 at defaults.
- RECOVER: spi_cs_n stays high for CLK_DIV cycles. On the final edge of RECOVER, done=1 for one cycle and busy=0 on the same edge. Next accept is possible the cycle after.
- Leading edge = transition away from CPOL; trailing edge = transition back to it.
- CPHA=0:
  - MOSI bit 0 of BYTE1 is driven at t0.
  - Each later bit is driven on the trailing edge; BYTE2 bit 0 is driven on the last BYTE1 trailing edge.
  - MISO is sampled on each leading edge.
- CPHA=1:
  - MOSI is driven on each leading edge.
  - MISO is sampled on each trailing edge.
- Sampling means spi_miso is registered on the same clk edge that toggles spi_clk to the sample level.
- BYTE1 MOSI = {wr_rdn, addr}. BYTE1 MISO is shifted into a capture register and copied to status at the end of BYTE1.
- BYTE2 MOSI:
  - Write (wr_rdn=1): wdata.
  - Read (wr_rdn=0): all zeros.
- BYTE2 MISO:
  - Read: captured and copied to rdata on the done edge.
  - Write: rdata is unchanged.
- spi_mosi returns to 0 when spi_cs_n rises. It holds its last value during GAP and HOLD.
- Width rules:
  - Divider counter: 8 bits, reloads CLK_DIV-1 and counts down.
  - Bit counter: $clog2(REG_W)+1 bits.
- ena=0 mid-frame freezes every counter and output; the frame resumes exactly where it stopped when ena returns.
- rst mid-frame immediately forces the reset values. spi_cs_n rises asynchronously and no done pulse is generated.

Optional Feature:
SPI_CTRL_STATUS_EN:
- Defined: status is captured during BYTE1 as described and holds until the next frame's BYTE1 completes.
- Undefined: the status port stays present but is tied to 0, and the BYTE1 MISO capture logic is removed. rdata behaviour is unaffected.

Test Plan:
1. Reset, defaults, mode=00, write with addr=0x05, wdata=0xA5 -> MOSI bits on leading edges = 0x85 then 0xA5; CS low for 140 cycles; 16 spi_clk rising edges; done one cycle; busy low with done; rdata unchanged at 0.
2. Read, mode=00, addr=0x12, peripheral model returning status=0x3C and rdata=0x5A -> BYTE2 MOSI = 0x00; status=0x3C and rdata=0x5A when done pulses.
3. Modes 01, 10, 11 repeating scenario 2 against a peripheral model -> spi_clk idles at CPOL in IDLE, GAP and HOLD; data captured correctly in every mode; rdata=0x5A.
4. start held high across a frame, plus a second start pulse at cycle 50 -> exactly one frame; next frame starts only after done; CS high for at least CLK_DIV=4 cycles between frames.
5. ena low for 20 cycles in the middle of BYTE2 -> spi_clk, MOSI and CS frozen; total CS-low width = 160 cycles; data still correct.
6. rst asserted during BYTE1 -> asynchronous spi_cs_n=1, busy=0, status=0, no done; a new frame after release completes normally.

Source files
------------

// File: rtl/spi_controller.sv
// SPI controller: originates two-byte register-access frames, a command
// byte {wr_rdn, addr} and then a data byte, both MSB first, for spi_peripheral.
// spi_clk is produced by dividing clk. The frame sequence is
// IDLE, SETUP, BYTE1, GAP, BYTE2, HOLD, RECOVER.
//
// Ports:
//   clk, rst       system clock; asynchronous active-high reset
//   ena            clock enable; when low, all state and outputs hold
//   mode           {CPOL, CPHA}, latched when a frame is accepted
//   start          frame request, accepted only in IDLE with ena high
//   wr_rdn         1 = write, 0 = read; latched on accept
//   addr, wdata    register address and write data; latched on accept
//   busy           high while a frame is in progress
//   done           one-cycle pulse when a frame completes
//   rdata          read data, updated at done for read frames only
//   status         status byte captured during the command byte
//   spi_clk        serial clock (registered)
//   spi_mosi       serial data out (registered)
//   spi_miso       serial data in
//   spi_cs_n       active-low chip select (registered)
//
// Optional feature macro: SPI_CTRL_STATUS_EN
//   Defined:   MISO is captured during BYTE1, and status holds that byte.
//   Undefined: status is tied to 0, and MISO is captured only in BYTE2.
module spi_controller #(
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             wr_rdn,
    input  logic [REG_W-2:0] addr,
    input  logic [REG_W-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] rdata,
    output logic [REG_W-1:0] status,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_cs_n
);

    localparam int              BW       = $clog2(REG_W) + 1;
    localparam int              FW       = 2 * REG_W;
    localparam logic [7:0]      DIV_LD   = 8'(CLK_DIV - 1);
    localparam logic [7:0]      GAP_LD   = 8'(GAP_CYC - 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(REG_W - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, BYTE1, GAP, BYTE2, HOLD, RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             wr_q, wr_d;
    logic [FW-1:0]    tx_q, tx_d;
    logic [REG_W-1:0] rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [REG_W-1:0] rdata_q, rdata_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;

    logic             tick;
    logic [7:0]       cnt_dec;
    logic             lead;
    logic             trail;
    logic             samp_en;
    logic [FW-1:0]    frame;

`ifdef SPI_CTRL_STATUS_EN
    logic [REG_W-1:0] status_q, status_d;
    assign samp_en = 1'b1;
    assign status  = status_q;
`else
    // Without the status feature, MISO is only captured during the data byte.
    assign samp_en = (state_q == BYTE2);
    assign status  = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        wr_d    = wr_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
`ifdef SPI_CTRL_STATUS_EN
        status_d = status_q;
`endif
        tick    = (cnt_q == 8'd0);
        cnt_dec = tick ? DIV_LD : cnt_q - 8'd1;
        lead    = 1'b0;
        trail   = 1'b0;
        frame   = {wr_rdn, addr, wr_rdn ? wdata : {REG_W{1'b0}}};

        if (ena) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    sclk_d = mode[1];
                    if (start) begin
                        state_d = SETUP;
                        cnt_d   = DIV_LD;
                        bit_d   = '0;
                        cpol_d  = mode[1];
                        cpha_d  = mode[0];
                        wr_d    = wr_rdn;
                        cs_n_d  = 1'b0;
                        busy_d  = 1'b1;
                        tx_d    = frame;
                        // CPHA=0 must present the first bit before any edge.
                        if (!mode[0]) begin
                            mosi_d = frame[FW-1];
                            tx_d   = {frame[FW-2:0], 1'b0};
                        end
                    end
                end
                SETUP, BYTE1, BYTE2: begin
                    cnt_d = cnt_dec;
                    if (tick) begin
                        sclk_d = ~sclk_q;
                        lead   = (sclk_q == cpol_q);
                        trail  = ~lead;
                    end
                    if (state_q == SETUP && tick) begin
                        state_d = BYTE1;
                    end
                    if (trail) begin
                        if (bit_q == LAST_BIT) begin
                            if (state_q == BYTE1) begin
                                state_d = GAP;
                                cnt_d   = GAP_LD;
                            end else begin
                                state_d = HOLD;
                            end
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                    // CPHA=0 shifts on trailing edges, except after the
                    // final bit of the frame.
                    if (cpha_q ? lead
                               : (trail && !(state_q == BYTE2 &&
                                             bit_q == LAST_BIT))) begin
                        mosi_d = tx_q[FW-1];
                        tx_d   = {tx_q[FW-2:0], 1'b0};
                    end
                    if ((cpha_q ? trail : lead) && samp_en) begin
                        rx_d = {rx_q[REG_W-2:0], spi_miso};
                    end
`ifdef SPI_CTRL_STATUS_EN
                    if (state_q == BYTE1 && trail && bit_q == LAST_BIT) begin
                        status_d = rx_d;
                    end
`endif
                end
                GAP: begin
                    cnt_d = cnt_dec;
                    if (tick) begin
                        state_d = BYTE2;
                        cnt_d   = DIV_LD;
                        bit_d   = '0;
                    end
                end
                HOLD: begin
                    cnt_d = cnt_dec;
                    if (tick) begin
                        state_d = RECOVER;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end
                end
                RECOVER: begin
                    cnt_d = cnt_dec;
                    if (tick) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (!wr_q) begin
                            rdata_d = rx_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            wr_q     <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
`ifdef SPI_CTRL_STATUS_EN
            status_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            wr_q     <= wr_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
`ifdef SPI_CTRL_STATUS_EN
            status_q <= status_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule
